button_debouncer: RTL and testbench

Conditions a raw, bouncing push-button into clean, single-cycle events on the system clock. Sits directly upstream of the lab counter stages (ripple counter, modulo divider) and replaces the raw button as their advance source. A 2-flop synchroniser feeds a debounce state machine, and an optional auto-repeat generator emits periodic steps while the button is held.

---
 rtl/button_debouncer.sv | 165 ++++++++++++++++
 tb/tb_button_debouncer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// Push-button conditioner: 2-flop synchroniser, debounce FSM, auto-repeat.
// Turns a raw bouncing button into a clean level and one-cycle events.
//
// Ports:
//   clk           in  system clock, rising edge
//   reset         in  asynchronous, active-low reset
//   btn_in        in  raw button, asynchronous, active-high
//   btn_level     out debounced button level
//   press_pulse   out one cycle on an accepted press
//   release_pulse out one cycle on an accepted release
//   repeat_pulse  out one cycle per auto-repeat step
//   step_pulse    out press_pulse | repeat_pulse
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter bit REPEAT_EN       = 1'b0,
   parameter int HOLD_CYCLES     = 50_000_000,
   parameter int REPEAT_CYCLES   = 10_000_000,
   parameter int CNT_WIDTH       = 26
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_in,
   output logic btn_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic repeat_pulse,
   output logic step_pulse
);

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      RELEASE_WAIT
   } state_t;

   localparam logic [CNT_WIDTH-1:0] DEB_LAST =
      CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] HOLD_LAST =
      CNT_WIDTH'(HOLD_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] REP_LAST =
      CNT_WIDTH'(REPEAT_CYCLES - 1);

   logic s1_q, s2_q;

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   // 0: waiting out the initial hold, 1: periodic repeat phase
   logic                 phase_q, phase_d;

   logic press_ev, release_ev, repeat_ev;

   logic level_q, level_d;
   logic press_q, press_d;
   logic release_q, release_d;
   logic repeat_q, repeat_d;
   logic step_q, step_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= btn_in;
         s2_q <= s1_q;
      end
   end

   // State register, including the registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         phase_q   <= 1'b0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         repeat_q  <= 1'b0;
         step_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         phase_q   <= phase_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         repeat_q  <= repeat_d;
         step_q    <= step_d;
      end
   end

   // Next-state logic; every transition clears the counter
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + CNT_WIDTH'(1);
      phase_d    = phase_q;
      press_ev   = 1'b0;
      release_ev = 1'b0;
      repeat_ev  = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (s2_q) state_d = PRESS_WAIT;
         end
         PRESS_WAIT: begin
            if (!s2_q) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == DEB_LAST) begin
               state_d  = HELD;
               cnt_d    = '0;
               phase_d  = 1'b0;
               press_ev = 1'b1;
            end
         end
         HELD: begin
            if (!s2_q) begin
               state_d = RELEASE_WAIT;
               cnt_d   = '0;
            end else if (!REPEAT_EN) begin
               cnt_d = '0;
            end else if (!phase_q && cnt_q == HOLD_LAST) begin
               cnt_d     = '0;
               phase_d   = 1'b1;
               repeat_ev = 1'b1;
            end else if (phase_q && cnt_q == REP_LAST) begin
               cnt_d     = '0;
               repeat_ev = 1'b1;
            end
         end
         RELEASE_WAIT: begin
            // A short low is a glitch: back to HELD, hold phase restarts
            if (s2_q) begin
               state_d = HELD;
               cnt_d   = '0;
               phase_d = 1'b0;
            end else if (cnt_q == DEB_LAST) begin
               state_d    = IDLE;
               cnt_d      = '0;
               release_ev = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Output logic, registered so no path exists from btn_in
   always_comb begin
      level_d   = (state_d == HELD) || (state_d == RELEASE_WAIT);
      press_d   = press_ev;
      release_d = release_ev;
      repeat_d  = repeat_ev;
      step_d    = press_ev | repeat_ev;
   end

   assign btn_level     = level_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign repeat_pulse  = repeat_q;
   assign step_pulse    = step_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: two instances (repeat off/on).
// Stimulus queues expected events; a monitor pops and compares.
module tb_button_debouncer;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic btn_in = 1'b0;

   logic lvl0, prs0, rel0, rep0, stp0;
   logic lvl1, prs1, rel1, rep1, stp1;
   logic [4:0] obs0, obs1;

   typedef struct packed {
      int unsigned cyc;
      logic [4:0]  o;
   } ev_t;

   // {level, press, release, repeat, step}
   localparam logic [4:0] E_PRESS = 5'b11001;
   localparam logic [4:0] E_REP   = 5'b10011;
   localparam logic [4:0] E_REL   = 5'b00100;
   localparam logic [4:0] E_DROP  = 5'b00000;
   localparam logic [4:0] E_HOLD  = 5'b10000;

   ev_t q0[$];
   ev_t q1[$];
   int n_tests = 0;
   int n_fail = 0;
   int unsigned edge_n = 0;
   int unsigned b;
   logic pl0 = 1'b0;
   logic pl1 = 1'b0;

   button_debouncer #(
      .DEBOUNCE_CYCLES(4),
      .REPEAT_EN(1'b0),
      .HOLD_CYCLES(10),
      .REPEAT_CYCLES(3),
      .CNT_WIDTH(26)
   ) u_norep (
      .clk(clk),
      .reset(reset),
      .btn_in(btn_in),
      .btn_level(lvl0),
      .press_pulse(prs0),
      .release_pulse(rel0),
      .repeat_pulse(rep0),
      .step_pulse(stp0)
   );

   button_debouncer #(
      .DEBOUNCE_CYCLES(4),
      .REPEAT_EN(1'b1),
      .HOLD_CYCLES(10),
      .REPEAT_CYCLES(3),
      .CNT_WIDTH(26)
   ) u_rep (
      .clk(clk),
      .reset(reset),
      .btn_in(btn_in),
      .btn_level(lvl1),
      .press_pulse(prs1),
      .release_pulse(rel1),
      .repeat_pulse(rep1),
      .step_pulse(stp1)
   );

   assign obs0 = {lvl0, prs0, rel0, rep0, stp0};
   assign obs1 = {lvl1, prs1, rel1, rep1, stp1};

   always #5 clk = ~clk;

   always @(posedge clk) edge_n <= edge_n + 1;

   // Monitor: any pulse or level change is an output event
   always @(negedge clk) begin
      ev_t e;
      if (obs0[3:0] != 4'b0 || obs0[4] != pl0) begin
         n_tests++;
         if (q0.size() == 0) begin
            n_fail++;
            $display("FAIL inst0 unexpected: edge %0d out %b, want none",
                     edge_n, obs0);
         end else begin
            e = q0.pop_front();
            if (e.cyc != edge_n || e.o != obs0) begin
               n_fail++;
               $display("FAIL inst0 event: edge %0d out %b, want edge %0d out %b",
                        edge_n, obs0, e.cyc, e.o);
            end
         end
      end
      pl0 = obs0[4];
      if (obs1[3:0] != 4'b0 || obs1[4] != pl1) begin
         n_tests++;
         if (q1.size() == 0) begin
            n_fail++;
            $display("FAIL inst1 unexpected: edge %0d out %b, want none",
                     edge_n, obs1);
         end else begin
            e = q1.pop_front();
            if (e.cyc != edge_n || e.o != obs1) begin
               n_fail++;
               $display("FAIL inst1 event: edge %0d out %b, want edge %0d out %b",
                        edge_n, obs1, e.cyc, e.o);
            end
         end
      end
      pl1 = obs1[4];
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic void push(input int k, input int unsigned c,
                                input logic [4:0] o);
      ev_t e;
      e.cyc = c;
      e.o   = o;
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
   endfunction

   task automatic drain(input string nm);
      n_tests++;
      if (q0.size() != 0 || q1.size() != 0) begin
         n_fail++;
         $display("FAIL %s missing events: inst0 %0d inst1 %0d, want 0 0",
                  nm, q0.size(), q1.size());
      end
      q0.delete();
      q1.delete();
   endtask

   task automatic chk_out(input string nm, input logic [4:0] w0,
                          input logic [4:0] w1);
      n_tests++;
      if (obs0 !== w0) begin
         n_fail++;
         $display("FAIL %s inst0: got %b want %b", nm, obs0, w0);
      end
      n_tests++;
      if (obs1 !== w1) begin
         n_fail++;
         $display("FAIL %s inst1: got %b want %b", nm, obs1, w1);
      end
   endtask

   initial begin
      // Reset state
      cyc(3);
      chk_out("reset", 5'b0, 5'b0);
      reset = 1'b1;
      cyc(2);

      // Clean press/release; auto-repeat on inst1
      b = edge_n;
      push(0, b + 7, E_PRESS);
      push(1, b + 7, E_PRESS);
      for (int r = 17; r <= 32; r += 3) push(1, b + r, E_REP);
      push(0, b + 37, E_REL);
      push(1, b + 37, E_REL);
      btn_in = 1'b1;
      cyc(30);
      btn_in = 1'b0;
      cyc(12);
      drain("clean_repeat");

      // Bounce rejection
      btn_in = 1'b1;
      cyc(3);
      btn_in = 1'b0;
      cyc(2);
      btn_in = 1'b1;
      cyc(2);
      btn_in = 1'b0;
      cyc(10);
      chk_out("bounce", 5'b0, 5'b0);
      drain("bounce");

      // Release glitch while held; hold phase restarts on inst1
      b = edge_n;
      push(0, b + 7, E_PRESS);
      push(1, b + 7, E_PRESS);
      push(1, b + 25, E_REP);
      push(1, b + 28, E_REP);
      push(1, b + 31, E_REP);
      push(0, b + 37, E_REL);
      push(1, b + 37, E_REL);
      btn_in = 1'b1;
      cyc(10);
      btn_in = 1'b0;
      cyc(2);
      btn_in = 1'b1;
      cyc(8);
      chk_out("glitch_held", E_HOLD, E_HOLD);
      cyc(10);
      btn_in = 1'b0;
      cyc(12);
      drain("glitch");

      // Long hold: inst0 single step, inst1 repeats
      b = edge_n;
      push(0, b + 7, E_PRESS);
      push(1, b + 7, E_PRESS);
      for (int r = 17; r <= 102; r += 3) push(1, b + r, E_REP);
      push(0, b + 107, E_REL);
      push(1, b + 107, E_REL);
      btn_in = 1'b1;
      cyc(100);
      btn_in = 1'b0;
      cyc(12);
      drain("long_hold");

      // Reset during PRESS_WAIT
      btn_in = 1'b1;
      cyc(4);
      #1 reset = 1'b0;
      #1 chk_out("rst_pw", 5'b0, 5'b0);
      cyc(3);
      reset = 1'b1;
      b = edge_n;
      push(0, b + 7, E_PRESS);
      push(1, b + 7, E_PRESS);
      cyc(10);

      // Reset while HELD: level drops with no clock edge
      push(0, edge_n + 1, E_DROP);
      push(1, edge_n + 1, E_DROP);
      #1 reset = 1'b0;
      #1 chk_out("rst_held", 5'b0, 5'b0);
      cyc(3);
      reset = 1'b1;
      b = edge_n;
      push(0, b + 7, E_PRESS);
      push(1, b + 7, E_PRESS);
      push(0, b + 17, E_REL);
      push(1, b + 17, E_REL);
      cyc(10);
      btn_in = 1'b0;
      cyc(12);
      drain("reset_mid");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
